// File: rtl/blackparrot_chip_pkg.sv
// Shared chip-level types and constants for the SDR link reset sequencer.
package blackparrot_chip_pkg;

    localparam int unsigned sdr_reset_hold_cycles_gp = 16;

    // Encoding order matters: the sequencer releases resets with ">=" compares on the state.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        TOKEN_HI = 3'd1,
        TOKEN_LO = 3'd2,
        UP_REL   = 3'd3,
        DOWN_REL = 3'd4,
        DSTR_REL = 3'd5,
        CORE_REL = 3'd6,
        DONE     = 3'd7
    } sdr_reset_seq_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear that saturates at max_val_p instead of wrapping.
module bsg_counter_clear_up #(
    parameter int unsigned max_val_p = 16,
    parameter int unsigned width_p   = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i)
            count_d = '0;
        else if (up_i && (count_q != width_p'(max_val_p)))
            count_d = count_q + width_p'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_blackparrot_sdr_reset_sequencer.sv
// Timed bring-up of the SDR link resets; every output is decoded from the state register.
// BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN adds the TOKEN_HI/TOKEN_LO token pulse phases.
module bsg_blackparrot_sdr_reset_sequencer
    import blackparrot_chip_pkg::*;
#(
    parameter int unsigned hold_cycles_p = sdr_reset_hold_cycles_gp,
    parameter int unsigned num_links_p   = 6
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic                   restart_i,
    output logic [num_links_p-1:0] uplink_reset_o,
    output logic [num_links_p-1:0] downlink_reset_o,
    output logic [num_links_p-1:0] downstream_reset_o,
    output logic [num_links_p-1:0] token_reset_o,
    output logic                   core_reset_o,
    output logic                   done_o
);

    localparam int unsigned cnt_width_lp = $clog2(hold_cycles_p + 1);
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(hold_cycles_p - 1);

    sdr_reset_seq_state_e state_q, state_d;
    logic [cnt_width_lp-1:0] cnt_lo;
    logic phase_done;
    logic cnt_clear, cnt_up;
    logic up_b, dn_b, ds_b, tok_b, core_b, done_b;

    assign phase_done = (cnt_lo == last_cnt_lp);
    assign cnt_clear  = restart_i || (state_d != state_q);
    assign cnt_up     = (state_q != IDLE) && (state_q != DONE);

    bsg_counter_clear_up #(
        .max_val_p(hold_cycles_p),
        .width_p  (cnt_width_lp)
    ) phase_cnt (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .clear_i  (cnt_clear),
        .up_i     (cnt_up),
        .count_o  (cnt_lo)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i)
`ifdef BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN
                    state_d = TOKEN_HI;
`else
                    state_d = UP_REL;
`endif
            end
`ifdef BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN
            TOKEN_HI: if (phase_done) state_d = TOKEN_LO;
            TOKEN_LO: if (phase_done) state_d = UP_REL;
`endif
            UP_REL:   if (phase_done) state_d = DOWN_REL;
            DOWN_REL: if (phase_done) state_d = DSTR_REL;
            DSTR_REL: if (phase_done) state_d = CORE_REL;
            CORE_REL: if (phase_done) state_d = DONE;
            DONE:     state_d = DONE;
            default:  state_d = IDLE;
        endcase
        if (restart_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        up_b   = (state_q < UP_REL);
        dn_b   = (state_q < DOWN_REL);
        ds_b   = (state_q < DSTR_REL);
        core_b = (state_q < CORE_REL);
        done_b = (state_q == DONE);
`ifdef BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN
        tok_b  = (state_q == TOKEN_HI);
`else
        tok_b  = dn_b;
`endif
    end

    assign uplink_reset_o     = {num_links_p{up_b}};
    assign downlink_reset_o   = {num_links_p{dn_b}};
    assign downstream_reset_o = {num_links_p{ds_b}};
    assign token_reset_o      = {num_links_p{tok_b}};
    assign core_reset_o       = core_b;
    assign done_o             = done_b;

endmodule

// File: tb/tb_bsg_blackparrot_sdr_reset_sequencer.sv
// Directed bench: per-cycle vector table on an H=4 instance plus hand sequences on an H=1 instance.
module tb_bsg_blackparrot_sdr_reset_sequencer;

    localparam int NL = 6;
`ifdef BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN
    localparam int NP = 6;
`else
    localparam int NP = 4;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, restart;
    logic [NL-1:0] a_up, a_dn, a_ds, a_tok;
    logic a_core, a_done;

    logic rst_n1, start1, restart1;
    logic [NL-1:0] b_up, b_dn, b_ds, b_tok;
    logic b_core, b_done;

    bsg_blackparrot_sdr_reset_sequencer #(.hold_cycles_p(4), .num_links_p(NL)) dut_h4 (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .restart_i(restart),
        .uplink_reset_o(a_up), .downlink_reset_o(a_dn), .downstream_reset_o(a_ds),
        .token_reset_o(a_tok), .core_reset_o(a_core), .done_o(a_done)
    );

    bsg_blackparrot_sdr_reset_sequencer #(.hold_cycles_p(1), .num_links_p(NL)) dut_h1 (
        .clk_i(clk), .reset_n_i(rst_n1), .start_i(start1), .restart_i(restart1),
        .uplink_reset_o(b_up), .downlink_reset_o(b_dn), .downstream_reset_o(b_ds),
        .token_reset_o(b_tok), .core_reset_o(b_core), .done_o(b_done)
    );

    typedef struct {
        logic rst_n;
        logic start;
        logic restart;
        bit   chk;
        int   d;      // cycles since the accepted start; 0 means IDLE outputs
    } vec_t;

    localparam int NV = 104;
    vec_t vt [NV];

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // Expected outputs d cycles after start was sampled, from the documented release points.
    function automatic logic [4*NL+1:0] seq_exp(input int d, input int h);
        logic up, dn, ds, tok, core, done;
`ifdef BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN
        up   = d < 2*h + 1;
        dn   = d < 3*h + 1;
        ds   = d < 4*h + 1;
        core = d < 5*h + 1;
        done = d >= 6*h + 1;
        tok  = (d >= 1) && (d <= h);
`else
        up   = d < 1;
        dn   = d < h + 1;
        ds   = d < 2*h + 1;
        core = d < 3*h + 1;
        done = d >= 4*h + 1;
        tok  = dn;
`endif
        return {{NL{up}}, {NL{dn}}, {NL{ds}}, {NL{tok}}, core, done};
    endfunction

    task automatic check(input string name, input logic [4*NL+1:0] act, input logic [4*NL+1:0] exp);
        chk_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;

        // Segment A: reset, start+restart together, start at 10, ignored starts,
        // restart at 25, new start at 30, start pulse while DONE.
        for (int c = 0; c < 64; c++) begin
            vt[c].rst_n   = (c >= 3);
            vt[c].start   = (c == 5) || (c == 10) || (c == 18) || (c == 19) || (c == 30) || (c == 60);
            vt[c].restart = (c == 5) || (c == 25);
            vt[c].chk     = (c >= 1);
            vt[c].d       = (c <= 10) ? 0 : (c <= 25) ? c - 10 : (c <= 30) ? 0 : c - 30;
        end
        // Segment B: start held high from 10, reset low over 20..24 mid-sequence.
        for (int j = 0; j < 40; j++) begin
            vt[64+j].rst_n   = !((j <= 2) || (j >= 20 && j <= 24));
            vt[64+j].start   = (j >= 10);
            vt[64+j].restart = 1'b0;
            vt[64+j].chk     = (j >= 1);
            vt[64+j].d       = (j <= 10) ? 0 : (j <= 20) ? j - 10 : (j <= 25) ? 0 : j - 25;
        end

        rst_n = 1'b0; start = 1'b0; restart = 1'b0;
        rst_n1 = 1'b0; start1 = 1'b0; restart1 = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            rst_n   = vt[i].rst_n;
            start   = vt[i].start;
            restart = vt[i].restart;
            if (vt[i].chk)
                check($sformatf("h4_vec%0d", i),
                      {a_up, a_dn, a_ds, a_tok, a_core, a_done}, seq_exp(vt[i].d, 4));
            tick();
        end

        // H=1: reset state, one-cycle phases, done latency, start ignored in DONE, restart.
        rst_n1 = 1'b0;
        tick();
        tick();
        rst_n1 = 1'b1;
        check("h1_reset", {b_up, b_dn, b_ds, b_tok, b_core, b_done}, seq_exp(0, 1));
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        k = 1;
        while (!b_done && k < 20) begin
            check($sformatf("h1_phase%0d", k), {b_up, b_dn, b_ds, b_tok, b_core, b_done}, seq_exp(k, 1));
            tick();
            k++;
        end
        chk_cnt++;
        if (k == NP + 1)
            pass_cnt++;
        else
            $display("FAIL h1_done_latency: done after %0d cycles, expected %0d", k, NP + 1);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        check("h1_start_in_done", {b_up, b_dn, b_ds, b_tok, b_core, b_done}, seq_exp(NP + 3, 1));
        tick();
        check("h1_done_held", {b_up, b_dn, b_ds, b_tok, b_core, b_done}, seq_exp(NP + 4, 1));

        restart1 = 1'b1;
        tick();
        restart1 = 1'b0;
        check("h1_restart_idle", {b_up, b_dn, b_ds, b_tok, b_core, b_done}, seq_exp(0, 1));
        tick();
        check("h1_idle_stays", {b_up, b_dn, b_ds, b_tok, b_core, b_done}, seq_exp(0, 1));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/bsg_blackparrot_sdr_reset_sequencer.md
BSG_BLACKPARROT_SDR_RESET_SEQUENCER -- requirements
Module: bsg_blackparrot_sdr_reset_sequencer

Interface
REQ-001 SHALL have parameter hold_cycles_p, default 16: the number of cycles each timed phase lasts; legal range >= 1.
REQ-002 SHALL have parameter num_links_p, default 6: fanout width of each link reset output (3 fwd + 3 rev SDR links).
REQ-003 SHALL have port clk_i  input  1  the single core clock.
REQ-004 SHALL have port reset_n_i  input  1  reset, synchronous to clk_i and active-low.
REQ-005 SHALL have port start_i  input  1  level; begins the bring-up sequence when sampled high in IDLE.
REQ-006 SHALL have port restart_i  input  1  level; aborts any phase and returns the block to IDLE.
REQ-007 SHALL have port uplink_reset_o  output  num_links_p  core uplink reset, replicated per link.
REQ-008 SHALL have port downlink_reset_o  output  num_links_p  downlink reset, replicated per link.
REQ-009 SHALL have port downstream_reset_o  output  num_links_p  core downstream reset, replicated per link.
REQ-010 SHALL have port token_reset_o  output  num_links_p  token reset, replicated per link.
REQ-011 SHALL have port core_reset_o  output  1  reset for the bridges and credit-to-ready converters.
REQ-012 SHALL have port done_o  output  1  high while the sequence is complete.

Function
REQ-013 States, in order: IDLE, TOKEN_HI, TOKEN_LO, UP_REL, DOWN_REL, DSTR_REL, CORE_REL, DONE.
REQ-014 All outputs SHALL be registered and decoded from the state register only; there is no combinational path from any input to any output.
REQ-015 IDLE outputs: uplink, downlink, downstream and core resets = 1; token = 0; done = 0.
REQ-016 token_reset_o SHALL be 1 only in TOKEN_HI.
REQ-017 Release order:
- uplink_reset_o = 0 from UP_REL onward.
- downlink_reset_o = 0 from DOWN_REL onward.
- downstream_reset_o = 0 from DSTR_REL onward.
- core_reset_o = 0 from CORE_REL onward.
- done_o = 1 only in DONE.
REQ-018 start_i sampled high in IDLE at edge t SHALL enter TOKEN_HI at t+1; start_i SHALL be ignored in all other states.
REQ-019 Each state from TOKEN_HI through CORE_REL SHALL last exactly hold_cycles_p cycles and then advance to the next state.
REQ-020 The phase counter SHALL be $clog2(hold_cycles_p+1) bits wide, SHALL clear on every state change, and SHALL saturate (no wrap).
REQ-021 With H = hold_cycles_p, done_o SHALL rise at t+1+6H.
REQ-022 DONE SHALL be held indefinitely until restart_i or reset.
REQ-023 restart_i high in any state SHALL move the block to IDLE at the next edge and clear the counter.
REQ-024 restart_i and start_i high together in IDLE: restart_i wins and the block stays in IDLE.
REQ-025 Releases SHALL be monotonic within a sequence: no reset output re-asserts except through restart or reset.

Reset
REQ-026 reset_n_i low at an edge SHALL force IDLE with IDLE outputs and a zero counter, regardless of state, including mid-sequence.
REQ-027 The first start_i SHALL be accepted in the cycle after reset_n_i returns high.

Configuration
REQ-028 Macro BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN defined: TOKEN_HI and TOKEN_LO exist as specified.
REQ-029 Macro BSG_SDR_RESET_SEQ_TOKEN_PULSE_EN undefined:
- TOKEN_HI and TOKEN_LO are removed; start_i in IDLE goes directly to UP_REL.
- token_reset_o SHALL equal downlink_reset_o.
- done_o SHALL rise at t+1+4H.

Structure
REQ-030 The state enum sdr_reset_seq_state_e and constant sdr_reset_hold_cycles_gp SHALL reside in blackparrot_chip_pkg.
REQ-031 The phase counter SHALL be one instance of bsg_counter_clear_up; there is no other sub-module.

Verification
REQ-032 Macro on, H=4, start_i pulsed at cycle 10 -> token high cycles 11-14; uplink drops at 19; downlink at 23; downstream at 27; core at 31; done at 35.
REQ-033 Macro off, H=4, start at cycle 10 -> uplink drops at 11; token and downlink drop at 15; downstream at 19; core at 23; done at 27.
REQ-034 restart_i at cycle 25 in the REQ-032 run -> all resets reasserted and done=0 at 26; a new start at 30 gives done at 55.
REQ-035 reset_n_i low at cycle 20 mid-sequence -> IDLE outputs at 21; start_i held high throughout is ignored until reset_n_i returns high.
REQ-036 start_i and restart_i high together in IDLE -> state remains IDLE and all outputs are unchanged.
REQ-037 H=1 -> each phase lasts one cycle and done rises at t+7; a start_i pulse while in DONE is ignored.
